// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-width
// encodings and the alignment test.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } lsu_state_t;

   // Access widths in bytes
   localparam logic [3:0] W_BYTE  = 4'd1;
   localparam logic [3:0] W_HALF  = 4'd2;
   localparam logic [3:0] W_WORD  = 4'd4;
   localparam logic [3:0] W_DWORD = 4'd8;

   // The 3-bit width field carries the byte count directly; 8 does not fit,
   // so its truncated encoding 3'b000 stands for a doubleword.
   function automatic logic [3:0] width_bytes(input logic [2:0] w);
      return (w == 3'd0) ? W_DWORD : {1'b0, w};
   endfunction

   // Legal widths are 1/2/4, plus 8 on an 8-byte bus
   function automatic logic width_legal(input logic [2:0] w, input int unsigned bus_bytes);
      logic [3:0] wb;
      wb = width_bytes(w);
      return (wb == W_BYTE) || (wb == W_HALF) || (wb == W_WORD) ||
             ((wb == W_DWORD) && (bus_bytes == 32'd8));
   endfunction

   // An access fits one bus word when its last byte stays inside the word
   function automatic logic is_aligned(input int unsigned off, input int unsigned wbytes,
                                       input int unsigned bus_bytes);
      return (off + wbytes) <= bus_bytes;
   endfunction

endpackage

// File: rtl/lsu_t_lane.sv
// Byte-lane steering for one access: write-lane mask, write-data shift and
// read-data extraction with zero/sign extension. NW is the number of bus
// words the access window spans (2 when misaligned accesses are split).
module lsu_lane_t
   import lsu_pkg::*;
#(
   parameter  int unsigned BUS_BYTES = 4,
   parameter  int unsigned NW        = 1,
   localparam int unsigned XLEN      = 8 * BUS_BYTES,
   localparam int unsigned OFF_W     = $clog2(BUS_BYTES),
   localparam int unsigned WB        = NW * BUS_BYTES,
   localparam int unsigned W         = NW * XLEN
) (
   input  logic [OFF_W-1:0] off_i,
   input  logic [3:0]       wbytes_i,
   input  logic             signed_i,
   input  logic [XLEN-1:0]  wdata_i,
   input  logic [W-1:0]     rdata_i,
   output logic [WB-1:0]    mask_c_o,
   output logic [W-1:0]     wdata_c_o,
   output logic [XLEN-1:0]  rdata_c_o
);

   logic [XLEN-1:0] shifted;
   logic            msb;

   // Lanes off .. off+wbytes-1 of the window are selected
   always_comb begin
      mask_c_o = '0;
      for (int i = 0; i < int'(WB); i++) begin
         if ((i >= int'(off_i)) && (i < int'(off_i) + int'(wbytes_i))) begin
            mask_c_o[i] = 1'b1;
         end
      end
   end

   assign wdata_c_o = W'(wdata_i) << {off_i, 3'b000};
   assign shifted   = XLEN'(rdata_i >> {off_i, 3'b000});

   // Keep the low wbytes bytes, fill the rest with zero or the top data bit
   always_comb begin
      msb = 1'b0;
      for (int b = 0; b < int'(BUS_BYTES); b++) begin
         if (b + 1 == int'(wbytes_i)) begin
            msb = shifted[8*b+7];
         end
      end
      for (int b = 0; b < int'(BUS_BYTES); b++) begin
         rdata_c_o[8*b +: 8] = (b < int'(wbytes_i)) ? shifted[8*b +: 8] : {8{signed_i & msb}};
      end
   end

endmodule

// File: rtl/lsu_t.sv
// Load/store unit: turns byte/half/word(/dword) requests into aligned bus
// beats and returns extended read data. Define LSU_MISALIGNED_EN to split
// word-crossing accesses into two beats; otherwise they return an error.
module lsu_t
   import lsu_pkg::*;
#(
   parameter int unsigned BUS_BYTES = 4,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [2:0]             req_width,
   input  logic                   req_signed,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [8*BUS_BYTES-1:0] req_wdata,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [8*BUS_BYTES-1:0] resp_rdata,
   output logic                   resp_err,
   output logic                   bus_valid,
   input  logic                   bus_ready,
   output logic [ADDR_W-1:0]      bus_addr,
   output logic [BUS_BYTES-1:0]   bus_wmask,
   output logic [8*BUS_BYTES-1:0] bus_wdata,
   input  logic [8*BUS_BYTES-1:0] bus_rdata
);

   localparam int unsigned XLEN  = 8 * BUS_BYTES;
   localparam int unsigned OFF_W = $clog2(BUS_BYTES);
`ifdef LSU_MISALIGNED_EN
   localparam int unsigned NW = 2;
`else
   localparam int unsigned NW = 1;
`endif

   lsu_state_t             state_q, state_d;
   logic [OFF_W-1:0]       off_q, off_d;
   logic [3:0]             wb_q, wb_d;
   logic                   write_q, write_d;
   logic                   signed_q, signed_d;
   logic [XLEN-1:0]        wdata_q, wdata_d;
   logic                   req_ready_q, req_ready_d;
   logic                   bus_valid_q, bus_valid_d;
   logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
   logic [BUS_BYTES-1:0]   bus_wmask_q, bus_wmask_d;
   logic [XLEN-1:0]        bus_wdata_q, bus_wdata_d;
   logic                   resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]        resp_rdata_q, resp_rdata_d;
   logic                   resp_err_q, resp_err_d;
`ifdef LSU_MISALIGNED_EN
   logic [XLEN-1:0]        lo_q, lo_d;
   logic                   cur_aligned;
`endif

   logic                   req_bad;
   logic                   finish;
   logic [OFF_W-1:0]       l_off;
   logic [3:0]             l_wb;
   logic [XLEN-1:0]        l_wdata;
   logic [NW*XLEN-1:0]     l_rdata;
   logic [NW*BUS_BYTES-1:0] l_mask;
   logic [NW*XLEN-1:0]     l_wsh;
   logic [XLEN-1:0]        l_rext;

   // Lane unit sees the incoming request in IDLE, the captured one afterwards
   always_comb begin
      if (state_q == IDLE) begin
         l_off   = req_addr[OFF_W-1:0];
         l_wb    = width_bytes(req_width);
         l_wdata = req_wdata;
      end else begin
         l_off   = off_q;
         l_wb    = wb_q;
         l_wdata = wdata_q;
      end
`ifdef LSU_MISALIGNED_EN
      l_rdata = (state_q == BEAT1) ? {bus_rdata, lo_q} : {{XLEN{1'b0}}, bus_rdata};
`else
      l_rdata = bus_rdata;
`endif
   end

   lsu_lane_t #(
      .BUS_BYTES (BUS_BYTES),
      .NW        (NW)
   ) u_lane (
      .off_i     (l_off),
      .wbytes_i  (l_wb),
      .signed_i  (signed_q),
      .wdata_i   (l_wdata),
      .rdata_i   (l_rdata),
      .mask_c_o  (l_mask),
      .wdata_c_o (l_wsh),
      .rdata_c_o (l_rext)
   );

   // Requests answered with an error and no bus beat
   always_comb begin
      req_bad = !width_legal(req_width, BUS_BYTES);
`ifndef LSU_MISALIGNED_EN
      if (!is_aligned(32'(req_addr[OFF_W-1:0]), 32'(width_bytes(req_width)), BUS_BYTES)) begin
         req_bad = 1'b1;
      end
`endif
   end

`ifdef LSU_MISALIGNED_EN
   assign cur_aligned = is_aligned(32'(off_q), 32'(wb_q), BUS_BYTES);
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      wb_d         = wb_q;
      write_d      = write_q;
      signed_d     = signed_q;
      wdata_d      = wdata_q;
      bus_valid_d  = bus_valid_q;
      bus_addr_d   = bus_addr_q;
      bus_wmask_d  = bus_wmask_q;
      bus_wdata_d  = bus_wdata_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
`ifdef LSU_MISALIGNED_EN
      lo_d         = lo_q;
`endif
      finish       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               off_d    = req_addr[OFF_W-1:0];
               wb_d     = width_bytes(req_width);
               write_d  = req_write;
               signed_d = req_signed;
               wdata_d  = req_wdata;
               if (req_bad) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d     = BEAT0;
                  bus_valid_d = 1'b1;
                  bus_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  bus_wmask_d = req_write ? l_mask[BUS_BYTES-1:0] : '0;
                  bus_wdata_d = l_wsh[XLEN-1:0];
               end
            end
         end
         BEAT0: begin
            if (bus_ready) begin
`ifdef LSU_MISALIGNED_EN
               if (!cur_aligned) begin
                  state_d     = BEAT1;
                  lo_d        = bus_rdata;
                  bus_addr_d  = bus_addr_q + ADDR_W'(BUS_BYTES);
                  bus_wmask_d = write_q ? l_mask[2*BUS_BYTES-1:BUS_BYTES] : '0;
                  bus_wdata_d = l_wsh[2*XLEN-1:XLEN];
               end else begin
                  finish = 1'b1;
               end
`else
               finish = 1'b1;
`endif
            end
         end
`ifdef LSU_MISALIGNED_EN
         BEAT1: begin
            if (bus_ready) begin
               finish = 1'b1;
            end
         end
`endif
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (finish) begin
         state_d      = RESP;
         bus_valid_d  = 1'b0;
         bus_wmask_d  = '0;
         resp_valid_d = 1'b1;
         resp_err_d   = 1'b0;
         resp_rdata_d = write_q ? '0 : l_rext;
      end

      req_ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         off_q        <= '0;
         wb_q         <= '0;
         write_q      <= 1'b0;
         signed_q     <= 1'b0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         bus_valid_q  <= 1'b0;
         bus_addr_q   <= '0;
         bus_wmask_q  <= '0;
         bus_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
`ifdef LSU_MISALIGNED_EN
         lo_q         <= '0;
`endif
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         wb_q         <= wb_d;
         write_q      <= write_d;
         signed_q     <= signed_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         bus_valid_q  <= bus_valid_d;
         bus_addr_q   <= bus_addr_d;
         bus_wmask_q  <= bus_wmask_d;
         bus_wdata_q  <= bus_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
`ifdef LSU_MISALIGNED_EN
         lo_q         <= lo_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign bus_valid  = bus_valid_q;
   assign bus_addr   = bus_addr_q;
   assign bus_wmask  = bus_wmask_q;
   assign bus_wdata  = bus_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: doc/lsu_t.md
LSU_T -- requirements
Module: lsu_t

Interface
REQ-001 SHALL have parameter BUS_BYTES, default 4, meaning the bus/data width in bytes; legal values are 4 and 8; XLEN = 8*BUS_BYTES.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk, input, 1 bit, the clock; reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL provide the request ports: req_valid in 1; req_ready out 1; req_write in 1; req_width in 3 (1/2/4/8 bytes); req_signed in 1; req_addr in ADDR_W; req_wdata in XLEN.
REQ-005 SHALL provide the response ports: resp_valid out 1; resp_ready in 1; resp_rdata out XLEN; resp_err out 1.
REQ-006 SHALL provide the bus ports: bus_valid out 1; bus_ready in 1; bus_addr out ADDR_W (always bus-aligned); bus_wmask out BUS_BYTES; bus_wdata out XLEN; bus_rdata in XLEN (valid in the cycle bus_valid && bus_ready).

Function
REQ-007 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-008 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid && req_ready.
REQ-009 SHALL, on accept at cycle T, enter BEAT0 with bus_valid=1 at T+1; bus outputs SHALL hold stable while bus_ready=0.
REQ-010 SHALL, for a beat completing at T+1 on an aligned access, enter RESP with resp_valid=1 at T+2; each bus stall cycle adds one cycle.
REQ-011 SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready; on resp_valid && resp_ready it returns to IDLE the next cycle (no back-to-back accept in the same cycle).
REQ-012 SHALL treat an access as aligned when (addr mod BUS_BYTES)+width <= BUS_BYTES.
REQ-013 SHALL set writes' bus_wmask to the width-byte lanes starting at addr mod BUS_BYTES, shift wdata by the same lane offset, and drive bus_wmask=0 for reads.
REQ-014 SHALL, for reads, shift the selected lanes down and zero-extend (req_signed=0) or sign-extend (req_signed=1) to XLEN.
REQ-015 SHALL treat req_width not in {1,2,4} (plus 8 when BUS_BYTES=8) as illegal: no bus beat; RESP at T+1 with resp_err=1 and resp_rdata=0.
REQ-016 SHALL use little-endian byte order.
REQ-017 SHALL wrap the second-beat address modulo 2^ADDR_W.

Reset
REQ-018 SHALL, on reset, set state=IDLE, bus_valid=0, bus_wmask=0, bus_addr=0, bus_wdata=0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready then reads 1.
REQ-019 SHALL let reset at any state abort the operation without completing a pending beat or response; a partial misaligned write is not rolled back.

Configuration
REQ-020 SHALL, with macro LSU_MISALIGNED_EN defined, split a misaligned access into BEAT0 (lower word, low lanes) then BEAT1 (next word, remaining lanes), with read data merged and extended after BEAT1; latency is two beats plus one.
REQ-021 SHALL, with LSU_MISALIGNED_EN undefined, answer a misaligned access with resp_err=1 and no bus beat (as in REQ-015), and omit the BEAT1 state logic.

Structure
REQ-022 SHALL place the state enum, width encodings (W_BYTE=1, W_HALF=2, W_WORD=4, W_DWORD=8) and the aligned-test function in shared package lsu_pkg.
REQ-023 SHALL implement lane mask, write shifting and read extraction in one combinational sub-module, lsu_lane_t, instantiated once per beat path.

Verification
REQ-024 SHALL cover: BUS_BYTES=4, read w=4 @0x100, bus_rdata=0xDEADBEEF, bus_ready=1 -> bus_addr=0x100, bus_wmask=0, resp_rdata=0xDEADBEEF at T+2.
REQ-025 SHALL cover: write w=1 @0x103, wdata=0xA5 -> bus_addr=0x100, bus_wmask=4'b1000, bus_wdata=0xA5000000, resp_err=0.
REQ-026 SHALL cover: signed read w=2 @0x102, bus_rdata=0x80010000 -> resp_rdata=0xFFFF8001; unsigned -> 0x00008001.
REQ-027 SHALL cover: LSU_MISALIGNED_EN, read w=4 @0x0FE, word 0x0FC=0xBBAA1122, word 0x100=0x99887766 -> beats at 0x0FC then 0x100, resp_rdata=0x7766BBAA at T+3; without the macro -> resp_err=1, bus_valid never 1.
REQ-028 SHALL cover: bus_ready=0 for 3 cycles in BEAT0 -> bus_addr, bus_wmask and bus_wdata stable, resp at T+5; resp_ready=0 for 2 cycles -> resp held and req_ready=0.
REQ-029 SHALL cover: reset asserted in BEAT1 -> next cycle bus_valid=0, resp_valid=0, req_ready=1; a new request then completes normally.
